// File: rtl/ddr_pkg.sv
// Shared DDR command encodings and command-arbiter state encoding.
// Used by the command FSM, the arbiter and the requester ports.
package ddr_pkg;

   localparam logic [3:0] CMD_RD     = 4'd1;
   localparam logic [3:0] CMD_WR     = 4'd2;
   localparam logic [3:0] CMD_RD_AP  = 4'd3;
   localparam logic [3:0] CMD_WR_AP  = 4'd4;
   localparam logic [3:0] CMD_PWRDWN = 4'd5;
   localparam logic [3:0] CMD_LMR    = 4'd6;
   localparam logic [3:0] CMD_SREF   = 4'd7;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StAckWait,
      StDoneWait
   } arb_state_e;

   function automatic logic cmd_legal(input logic [3:0] c);
      return (c >= CMD_RD) && (c <= CMD_SREF);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first request at or after ptr+1 (wrapping) wins; the
// pointer moves to the winner only when the caller consumes the grant.
module rr_pick #(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       advance,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   logic [IW-1:0] ptr_q;

   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         j = int'(ptr_q) + 1 + k;
         if (j >= int'(NUM_REQ)) j = j - int'(NUM_REQ);
         if (!any && req[j]) begin
            any      = 1'b1;
            idx      = IW'(j);
            grant[j] = 1'b1;
         end
      end
   end

   // Reset to the last slot so requester 0 is first in line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= IW'(NUM_REQ - 1);
      end else if (advance && any) begin
         ptr_q <= idx;
      end
   end

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Shares the DDR command FSM between NUM_REQ requesters, one command in flight.
// Optional macro REQ0_PRIORITY_EN gives requester 0 absolute priority.
module ddr_cmd_arbiter
   import ddr_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 3,
   parameter int unsigned ADDR_W      = 24,
   parameter int unsigned ACK_TIMEOUT = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        init_done,
   input  logic                        busy,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [4*NUM_REQ-1:0]        req_cmd,
   input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          req_done,
   output logic [NUM_REQ-1:0]          req_err,
   output logic [3:0]                  cmd,
   output logic                        cmd_valid,
   output logic [ADDR_W-1:0]           addr,
   output logic [$clog2(NUM_REQ)-1:0]  owner,
   output logic                        owner_valid
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;

   logic [NUM_REQ-1:0] pick_req, pick_grant, win_grant, owner_oh;
   logic [IW-1:0]      pick_idx, win_idx;
   logic               pick_any, win_any, pick_adv, grant_ok, latch;
   logic [3:0]         sel_cmd;
   logic [ADDR_W-1:0]  sel_addr;

   arb_state_e         state_q, state_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [3:0]         cmd_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [IW-1:0]      owner_q;
   logic               owner_valid_q, owner_valid_d;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .clk     (clk),
      .rst     (rst),
      .req     (pick_req),
      .advance (pick_adv),
      .grant   (pick_grant),
      .idx     (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
`ifdef REQ0_PRIORITY_EN
      // Requester 0 bypasses the rotation and leaves the pointer alone.
      pick_req = {req_valid[NUM_REQ-1:1], 1'b0};
      if (req_valid[0]) begin
         win_any   = 1'b1;
         win_idx   = '0;
         win_grant = NUM_REQ'(1);
      end else begin
         win_any   = pick_any;
         win_idx   = pick_idx;
         win_grant = pick_grant;
      end
      grant_ok = (state_q == StIdle) && init_done && !busy && win_any;
      pick_adv = grant_ok && !req_valid[0];
`else
      pick_req  = req_valid;
      win_any   = pick_any;
      win_idx   = pick_idx;
      win_grant = pick_grant;
      grant_ok  = (state_q == StIdle) && init_done && !busy && win_any;
      pick_adv  = grant_ok;
`endif
   end

   always_comb begin
      sel_cmd  = '0;
      sel_addr = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (win_idx == IW'(i)) begin
            sel_cmd  = req_cmd[4*i +: 4];
            sel_addr = req_addr[ADDR_W*i +: ADDR_W];
         end
      end
   end

   assign owner_oh = NUM_REQ'(1) << owner_q;

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      owner_valid_d = owner_valid_q;
      latch         = 1'b0;
      req_ready     = '0;
      req_done      = '0;
      req_err       = '0;
      cmd_valid     = 1'b0;
      if (state_q != StIdle && !init_done) begin
         // Losing init mid-command: the command is void, report it and drop it.
         req_err       = owner_oh;
         owner_valid_d = 1'b0;
         state_d       = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_ok) begin
                  req_ready = win_grant;
                  if (cmd_legal(sel_cmd)) begin
                     latch         = 1'b1;
                     owner_valid_d = 1'b1;
                     state_d       = StIssue;
                  end else begin
                     req_err = win_grant;
                  end
               end
            end
            StIssue: begin
               cmd_valid = 1'b1;
               timer_d   = '0;
               state_d   = StAckWait;
            end
            StAckWait: begin
               if (busy) begin
                  state_d = StDoneWait;
               end else begin
                  timer_d = timer_q + 1'b1;
                  if (timer_d == TW'(ACK_TIMEOUT - 1)) state_d = StIssue;
               end
            end
            StDoneWait: begin
               if (!busy) begin
                  req_done      = owner_oh;
                  owner_valid_d = 1'b0;
                  state_d       = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         timer_q       <= '0;
         cmd_q         <= '0;
         addr_q        <= '0;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         owner_valid_q <= owner_valid_d;
         if (latch) begin
            cmd_q   <= sel_cmd;
            addr_q  <= sel_addr;
            owner_q <= win_idx;
         end
      end
   end

   assign cmd         = cmd_q;
   assign addr        = addr_q;
   assign owner       = owner_q;
   assign owner_valid = owner_valid_q;

endmodule
